// File: rtl/reduce_clause.sv
// reduce_clause
//   Reduces one linear integer clause  a0*y0 + ... + a(N-1)*y(N-1) <= b  to a
//   single-variable bound (+/-)yk <= bias on the chosen variable yk, with every
//   other variable held at its current assignment. One result per cycle, one
//   cycle of latency, no handshake: in_enable is a plain capture strobe.
//
// Ports
//   in_clk                            rising-edge clock
//   in_reset                          asynchronous active-high reset (clears outputs)
//   in_coefficients                   (N+1)*W: field i = signed ai, field N = signed b
//   in_current_assignment             N*W: field i = signed yi
//   in_variable_to_be_unchanged_index k, the variable the clause is reduced to
//   in_enable                         load the result for the current inputs
//   out_bias                          signed bias of (+/-)yk <= bias (saturated to W bits)
//   out_variable_to_be_unchanged_sign 0: +yk (ak>0), 1: -yk (ak<0)
//   out_active                        1 when k is a valid index and ak != 0

module reduce_clause #(
  parameter int NUMBER_OF_INTEGER_VARIABLES         = 2,
  parameter int BIT_WIDTH_OF_INTEGER_VARIABLE       = 8,
  parameter int BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1
) (
  input  logic                                                                 in_clk,
  input  logic                                                                 in_reset,
  input  logic [(NUMBER_OF_INTEGER_VARIABLES+1)*BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_coefficients,
  input  logic [NUMBER_OF_INTEGER_VARIABLES*BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]     in_current_assignment,
  input  logic [BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX-1:0]                           in_variable_to_be_unchanged_index,
  input  logic                                                                 in_enable,
  output logic [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]                                 out_bias,
  output logic                                                                 out_variable_to_be_unchanged_sign,
  output logic                                                                 out_active
);

  localparam int N  = NUMBER_OF_INTEGER_VARIABLES;
  localparam int W  = BIT_WIDTH_OF_INTEGER_VARIABLE;
  // Residual width: 2W-bit products, clog2(N+1) bits of accumulation growth,
  // plus one guard bit so negating the most negative residual cannot wrap.
  localparam int RW = 2*W + $clog2(N+1) + 1;

  localparam logic signed [RW:0] MAX_BIAS = (RW+1)'(2**(W-1) - 1);
  localparam logic signed [RW:0] MIN_BIAS = (RW+1)'(-(2**(W-1)));

  int                     k_int;
  logic                   k_valid;
  logic signed [W-1:0]    ak;
  logic signed [W-1:0]    b;
  logic signed [W-1:0]    a_i;
  logic signed [W-1:0]    y_i;
  logic signed [2*W-1:0]  prod;
  logic signed [RW-1:0]   r;
  logic                   r_neg;
  logic [RW-1:0]          r_mag;
  logic [W-1:0]           ak_mag;
  logic [W:0]             rem;
  logic [RW-1:0]          q;
  logic [RW:0]            q_mag;
  logic signed [RW:0]     qs;
  logic [W-1:0]           bias_next;
  logic                   sign_next;
  logic                   active_next;

  always_comb begin
    k_int       = int'(in_variable_to_be_unchanged_index);
    k_valid     = (k_int < N);
    ak          = '0;
    a_i         = '0;
    y_i         = '0;
    prod        = '0;
    rem         = '0;
    q           = '0;
    bias_next   = '0;
    sign_next   = 1'b0;

    if (k_valid) ak = in_coefficients[k_int*W +: W];
    b = in_coefficients[N*W +: W];

    // r = b - sum of ai*yi over every variable except yk
    r = {{(RW-W){b[W-1]}}, b};
    for (int i = 0; i < N; i++) begin
      a_i  = in_coefficients[i*W +: W];
      y_i  = in_current_assignment[i*W +: W];
      prod = a_i * y_i;
      if (i != k_int) r = r - {{(RW-2*W){prod[2*W-1]}}, prod};
    end

    // Divide magnitudes, then fix up the sign so the quotient floors.
    r_neg  = r[RW-1];
    r_mag  = r_neg ? $unsigned(-r) : $unsigned(r);
    ak_mag = ak[W-1] ? $unsigned(-ak) : $unsigned(ak);

    // Restoring division, one quotient bit per row.
    for (int i = RW-1; i >= 0; i--) begin
      rem = {rem[W-1:0], r_mag[i]};
      if (rem >= {1'b0, ak_mag}) begin
        rem  = rem - {1'b0, ak_mag};
        q[i] = 1'b1;
      end
    end

    // A negative residual with a nonzero remainder rounds one further down.
    q_mag = {1'b0, q} + {{RW{1'b0}}, (rem != '0)};
    qs    = r_neg ? -$signed(q_mag) : $signed({1'b0, q});

    active_next = k_valid && (ak != '0);
    if (active_next) begin
      sign_next = ak[W-1];
      if (qs > MAX_BIAS)      bias_next = {1'b0, {(W-1){1'b1}}};
      else if (qs < MIN_BIAS) bias_next = {1'b1, {(W-1){1'b0}}};
      else                    bias_next = qs[W-1:0];
    end
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      out_bias                          <= '0;
      out_variable_to_be_unchanged_sign <= 1'b0;
      out_active                        <= 1'b0;
    end else if (in_enable) begin
      out_bias                          <= bias_next;
      out_variable_to_be_unchanged_sign <= sign_next;
      out_active                        <= active_next;
    end
  end

endmodule

// File: tb/tb_reduce_clause.sv
// Directed bench for reduce_clause with N=2, W=8. Each step drives one
// clause, clocks one enabled edge and compares {bias, sign, active} against
// hand-computed values.

module tb_reduce_clause;

  logic        in_clk;
  logic        in_reset;
  logic [23:0] in_coefficients;
  logic [15:0] in_current_assignment;
  logic [0:0]  in_variable_to_be_unchanged_index;
  logic        in_enable;
  logic [7:0]  out_bias;
  logic        out_variable_to_be_unchanged_sign;
  logic        out_active;

  int errors = 0;
  int checks = 0;

  reduce_clause #(
    .NUMBER_OF_INTEGER_VARIABLES(2),
    .BIT_WIDTH_OF_INTEGER_VARIABLE(8),
    .BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX(1)
  ) dut (
    .in_clk(in_clk),
    .in_reset(in_reset),
    .in_coefficients(in_coefficients),
    .in_current_assignment(in_current_assignment),
    .in_variable_to_be_unchanged_index(in_variable_to_be_unchanged_index),
    .in_enable(in_enable),
    .out_bias(out_bias),
    .out_variable_to_be_unchanged_sign(out_variable_to_be_unchanged_sign),
    .out_active(out_active)
  );

  // clock
  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [7:0] bias_e,
                       input logic sign_e, input logic active_e);
    logic [9:0] got;
    logic [9:0] exp;
    got = {out_bias, out_variable_to_be_unchanged_sign, out_active};
    exp = {bias_e, sign_e, active_e};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: bias/sign/active got %h/%b/%b expected %h/%b/%b",
             tag, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
    end
  endtask

  // Drive one clause, clock one enabled edge, sample 1 time unit later.
  task automatic run(input logic [23:0] c, input logic [15:0] a, input logic k);
    in_coefficients                   = c;
    in_current_assignment             = a;
    in_variable_to_be_unchanged_index = k;
    in_enable                         = 1'b1;
    @(posedge in_clk);
    #1;
    in_enable = 1'b0;
  endtask

  initial begin
    in_reset                          = 1'b1;
    in_enable                         = 1'b0;
    in_coefficients                   = '0;
    in_current_assignment             = '0;
    in_variable_to_be_unchanged_index = '0;

    repeat (3) @(posedge in_clk);
    #1;
    check("reset_state", 8'h00, 1'b0, 1'b0);

    // Enabled edge while reset is held must not load anything.
    run(24'h010101, 16'h0101, 1'b0);
    check("reset_blocks_enable", 8'h00, 1'b0, 1'b0);
    in_reset = 1'b0;

    run(24'h010101, 16'h0101, 1'b0);
    check("x0_plus_x1", 8'h00, 1'b0, 1'b1);

    run(24'h0001FF, 16'h0101, 1'b0);
    check("neg_coef_k0", 8'hFF, 1'b1, 1'b1);

    run(24'h040102, 16'h0102, 1'b1);
    check("two_x0_k1", 8'h00, 1'b0, 1'b1);

    run(24'h040102, 16'h0102, 1'b0);
    check("floor_3_div_2", 8'h01, 1'b0, 1'b1);

    run(24'h040100, 16'h0102, 1'b1);
    check("a0_zero_k1", 8'h04, 1'b0, 1'b1);

    run(24'h040100, 16'h0102, 1'b0);
    check("absent_var", 8'h00, 1'b0, 1'b0);

    run(24'hFD02FE, 16'h0000, 1'b0);
    check("floor_neg3_div_neg2", 8'hFE, 1'b1, 1'b1);

    // r=-3 with ak=+2 -> floor(-1.5) = -2, positive sign
    run(24'hFD0102, 16'h0000, 1'b0);
    check("floor_neg3_div_pos2", 8'hFE, 1'b0, 1'b1);

    // ak=-128: |ak|=128, r=10 -> 0, negative sign
    run(24'h0A0180, 16'h0000, 1'b0);
    check("ak_min_neg", 8'h00, 1'b1, 1'b1);

    // b=-128, a1=1, y1=127 -> r=-255 saturates to -128
    run(24'h800101, 16'h7F00, 1'b0);
    check("sat_low", 8'h80, 1'b0, 1'b1);

    // r = 127 - (1 * -1) = 128 saturates to 127
    run(24'h7F0101, 16'h80FF, 1'b1);
    check("sat_high", 8'h7F, 1'b0, 1'b1);

    // Changed inputs with enable low: outputs hold.
    in_coefficients                   = 24'h0001FF;
    in_current_assignment             = 16'h0101;
    in_variable_to_be_unchanged_index = 1'b0;
    in_enable                         = 1'b0;
    @(posedge in_clk);
    #1;
    check("enable_low_hold", 8'h7F, 1'b0, 1'b1);

    // Asynchronous reset mid-stream, away from any clock edge.
    #2;
    in_reset = 1'b1;
    #1;
    check("async_reset_clear", 8'h00, 1'b0, 1'b0);
    @(posedge in_clk);
    #1;
    in_reset = 1'b0;

    // Edge without enable after release keeps the cleared outputs.
    @(posedge in_clk);
    #1;
    check("post_reset_idle", 8'h00, 1'b0, 1'b0);

    run(24'h0001FF, 16'h0101, 1'b0);
    check("first_after_reset", 8'hFF, 1'b1, 1'b1);

    // Back-to-back results, one per cycle.
    in_coefficients                   = 24'h040102;
    in_current_assignment             = 16'h0102;
    in_variable_to_be_unchanged_index = 1'b0;
    in_enable                         = 1'b1;
    @(posedge in_clk);
    #1;
    check("b2b_first", 8'h01, 1'b0, 1'b1);
    in_variable_to_be_unchanged_index = 1'b1;
    @(posedge in_clk);
    #1;
    check("b2b_second", 8'h00, 1'b0, 1'b1);
    in_enable = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
